spi_master_engine: RTL

//  SPI shift engine directly downstream of the Wishbone SPI control-register slave.
//  - Consumes the slave's 32-bit TX word, start bit and 2-bit chip-select index.
//  - Runs one 32-bit, MSB-first, mode-0 (CPOL=0, CPHA=0) full-duplex transfer.
//  - Returns the RX word and a done level that the slave exposes in its control register.

---
 rtl/spi_master_engine_pkg.sv | 26 ++
 rtl/spi_master_engine_if.sv | 23 ++
 rtl/spi_master_engine_sclk_gen.sv | 46 ++++
 rtl/spi_master_engine.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/spi_master_engine_pkg.sv
// Shared definitions for the SPI master shift engine: word/select widths,
// FSM state encoding and the chip-select decode helper.
package spi_master_engine_pkg;

    localparam int SPI_WORD_W = 32;
    localparam int CS_COUNT   = 4;
    localparam int SEL_W      = $clog2(CS_COUNT);
    localparam int BIT_CNT_W  = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // One-hot-low chip select for the given index.
    function automatic logic [CS_COUNT-1:0] cs_decode(input logic [SEL_W-1:0] sel);
        logic [CS_COUNT-1:0] cs_n;
        cs_n      = '1;
        cs_n[sel] = 1'b0;
        return cs_n;
    endfunction

endpackage

// File: rtl/spi_master_engine_if.sv
// Register-slave side bus of the SPI engine: TX word, start, select in;
// RX word, done and busy out.
interface spi_master_engine_if;
    import spi_master_engine_pkg::*;

    logic [SPI_WORD_W-1:0] spi_dat_i;
    logic                  spi_start_i;
    logic [SEL_W-1:0]      spi_sel_i;
    logic [SPI_WORD_W-1:0] spi_dat_o;
    logic                  spi_done_o;
    logic                  busy_o;

    modport master (
        input  spi_dat_i, spi_start_i, spi_sel_i,
        output spi_dat_o, spi_done_o, busy_o
    );

    modport slave (
        output spi_dat_i, spi_start_i, spi_sel_i,
        input  spi_dat_o, spi_done_o, busy_o
    );

endinterface

// File: rtl/spi_master_engine_sclk_gen.sv
// SCLK generator: half-period divider that toggles SCLK while enabled and
// flags the clk_i edge on which SCLK rises or falls.
module spi_master_engine_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);

    localparam int            DW       = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          sclk_q, sclk_d;
    logic          wrap;

    // Disabled: divider and SCLK are parked at zero so each SHIFT starts with a full low half.
    always_comb begin
        wrap   = en_i && (div_q == DIV_LAST);
        div_d  = '0;
        sclk_d = 1'b0;
        if (en_i) begin
            div_d  = wrap ? '0 : div_q + DW'(1);
            sclk_d = wrap ? ~sclk_q : sclk_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o      = sclk_q;
    assign rise_tick_o = wrap & ~sclk_q;
    assign fall_tick_o = wrap &  sclk_q;

endmodule

// File: rtl/spi_master_engine.sv
// SPI mode-0 master: one 32-bit MSB-first full-duplex transfer per rising
// edge of start, with SETUP/HOLD chip-select guard times of CLK_DIV cycles.
module spi_master_engine
    import spi_master_engine_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    spi_master_engine_if.master bus,
    output logic                sclk_o,
    output logic                mosi_o,
    input  logic                miso_i,
    output logic [CS_COUNT-1:0] cs_n_o
);

    localparam int            DW       = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] CNT_LAST = DW'(CLK_DIV - 1);

    state_e                state_q, state_d;
    logic                  start_q;
    logic                  start_rise;
    logic [SPI_WORD_W-1:0] tx_sr_q, tx_sr_d;
    logic [SPI_WORD_W-1:0] rx_sr_q, rx_sr_d;
    logic [SPI_WORD_W-1:0] rx_word_q, rx_word_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]         cnt_q, cnt_d;
    logic [CS_COUNT-1:0]   cs_n_q, cs_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  active_d;
    logic                  shift_en;
    logic                  rise_tick;
    logic                  fall_tick;

    assign start_rise = bus.spi_start_i & ~start_q;
    assign shift_en   = (state_q == ST_SHIFT);

    spi_master_engine_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .en_i        (shift_en),
        .sclk_o      (sclk_o),
        .rise_tick_o (rise_tick),
        .fall_tick_o (fall_tick)
    );

    always_comb begin
        state_d   = state_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_word_d = rx_word_q;
        sel_d     = sel_q;
        bit_cnt_d = bit_cnt_q;
        cnt_d     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    tx_sr_d = bus.spi_dat_i;
                    sel_d   = bus.spi_sel_i;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                bit_cnt_d = '0;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            ST_SHIFT: begin
                if (rise_tick) begin
                    rx_sr_d = {rx_sr_q[SPI_WORD_W-2:0], miso_i};
                end
                if (fall_tick) begin
                    tx_sr_d   = {tx_sr_q[SPI_WORD_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == BIT_CNT_W'(SPI_WORD_W - 1)) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_LAST) begin
                    rx_word_d = rx_sr_q;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            ST_DONE: begin
                if (!bus.spi_start_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so cs_n/busy/done never glitch.
        active_d = (state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD);
        busy_d   = active_d;
        cs_n_d   = active_d ? cs_decode(sel_d) : '1;
        done_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_IDLE;
            start_q   <= 1'b0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_word_q <= '0;
            sel_q     <= '0;
            bit_cnt_q <= '0;
            cnt_q     <= '0;
            cs_n_q    <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= bus.spi_start_i;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_word_q <= rx_word_d;
            sel_q     <= sel_d;
            bit_cnt_q <= bit_cnt_d;
            cnt_q     <= cnt_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign mosi_o         = tx_sr_q[SPI_WORD_W-1];
    assign cs_n_o         = cs_n_q;
    assign bus.spi_dat_o  = rx_word_q;
    assign bus.spi_done_o = done_q;
    assign bus.busy_o     = busy_q;

endmodule
